// File: rtl/friscv_axil_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : friscv_axil_apb_bridge
// Purpose  : AXI4-lite slave to single-target APB-style master bridge for the
//            CLINT register port. One transaction is in flight at a time.
//            The bridge decodes the address against a base window, alternates
//            between reads and writes when both are pending, bounds the wait
//            for mst_ready with a timeout, and returns DECERR or SLVERR on the
//            AXI side when an access misses the window or times out.
// Ports    : aclk, areset (async, active-high), srst (sync, active-high)
//            AXI4-lite AW/W/B/AR/R channels (slave side)
//            mst_en/mst_wr/mst_addr/mst_wdata/mst_strb out,
//            mst_rdata/mst_ready in (peripheral side)
//            Every output is driven straight from a flop.
// Revision : 1.0 - initial release
// ============================================================================
module friscv_axil_apb_bridge #(
  parameter int                   AXI_ADDRW = 32,
  parameter int                   APB_ADDRW = 16,
  parameter int                   XLEN      = 32,
  parameter logic [AXI_ADDRW-1:0] BASE_ADDR = 32'h0200_0000,
  parameter int                   TIMEOUT   = 255
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 srst,
  // write address / data / response
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [AXI_ADDRW-1:0] awaddr,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN/8-1:0]    wstrb,
  output logic                 bvalid,
  input  logic                 bready,
  output logic [1:0]           bresp,
  // read address / data
  input  logic                 arvalid,
  output logic                 arready,
  input  logic [AXI_ADDRW-1:0] araddr,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [XLEN-1:0]      rdata,
  output logic [1:0]           rresp,
  // peripheral master
  output logic                 mst_en,
  output logic                 mst_wr,
  output logic [APB_ADDRW-1:0] mst_addr,
  output logic [XLEN-1:0]      mst_wdata,
  output logic [XLEN/8-1:0]    mst_strb,
  input  logic [XLEN-1:0]      mst_rdata,
  input  logic                 mst_ready
);

  localparam int                             c_strbw      = XLEN / 8;
  localparam logic [AXI_ADDRW-APB_ADDRW-1:0] c_base_hi    = BASE_ADDR[AXI_ADDRW-1:APB_ADDRW];
  // Last counter value at which mst_en is still high; mst_en stays up for
  // exactly TIMEOUT cycles when the peripheral never answers.
  localparam logic [7:0]                     c_cnt_last   = 8'(TIMEOUT - 1);
  localparam logic [1:0]                     c_resp_okay  = 2'b00;
  localparam logic [1:0]                     c_resp_slv   = 2'b10;
  localparam logic [1:0]                     c_resp_dec   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRESP  = 2'd2,
    RRESP  = 2'd3
  } state_t;

  state_t               state_q,     state_d;
  logic                 awready_q,   awready_d;
  logic                 wready_q,    wready_d;
  logic                 arready_q,   arready_d;
  logic                 bvalid_q,    bvalid_d;
  logic [1:0]           bresp_q,     bresp_d;
  logic                 rvalid_q,    rvalid_d;
  logic [XLEN-1:0]      rdata_q,     rdata_d;
  logic [1:0]           rresp_q,     rresp_d;
  logic                 mst_en_q,    mst_en_d;
  logic                 mst_wr_q,    mst_wr_d;
  logic [APB_ADDRW-1:0] mst_addr_q,  mst_addr_d;
  logic [XLEN-1:0]      mst_wdata_q, mst_wdata_d;
  logic [c_strbw-1:0]   mst_strb_q,  mst_strb_d;
  logic                 rd_prio_q,   rd_prio_d;   // 1: read wins a tie
  logic                 is_wr_q,     is_wr_d;     // direction of the granted transaction
  logic                 hit_q,       hit_d;       // granted address inside the window
  logic [7:0]           cnt_q,       cnt_d;       // ACCESS wait counter

  logic w_wr_cand;
  logic w_rd_cand;
  logic w_aw_hit;
  logic w_ar_hit;

  assign w_wr_cand = awvalid && wvalid;
  assign w_rd_cand = arvalid;
  assign w_aw_hit  = (awaddr[AXI_ADDRW-1:APB_ADDRW] == c_base_hi);
  assign w_ar_hit  = (araddr[AXI_ADDRW-1:APB_ADDRW] == c_base_hi);

  always_comb begin
    state_d     = state_q;
    awready_d   = 1'b0;
    wready_d    = 1'b0;
    arready_d   = 1'b0;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    mst_en_d    = mst_en_q;
    mst_wr_d    = mst_wr_q;
    mst_addr_d  = mst_addr_q;
    mst_wdata_d = mst_wdata_q;
    mst_strb_d  = mst_strb_q;
    rd_prio_d   = rd_prio_q;
    is_wr_d     = is_wr_q;
    hit_d       = hit_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (awready_q || arready_q) begin
          // The ready pulse is on the bus now, so the AXI handshake completes
          // at this edge: launch the access or answer a window miss directly.
          if (hit_q) begin
            state_d  = ACCESS;
            mst_en_d = 1'b1;
            mst_wr_d = is_wr_q;
            cnt_d    = 8'd0;
          end else if (is_wr_q) begin
            state_d  = WRESP;
            bvalid_d = 1'b1;
            bresp_d  = c_resp_dec;
          end else begin
            state_d  = RRESP;
            rvalid_d = 1'b1;
            rresp_d  = c_resp_dec;
            rdata_d  = '0;
          end
        end else if (w_wr_cand && (!w_rd_cand || !rd_prio_q)) begin
          awready_d = 1'b1;
          wready_d  = 1'b1;
          is_wr_d   = 1'b1;
          hit_d     = w_aw_hit;
          rd_prio_d = 1'b1;
          if (w_aw_hit) begin
            mst_addr_d  = awaddr[APB_ADDRW-1:0];
            mst_wdata_d = wdata;
            mst_strb_d  = wstrb;
          end
        end else if (w_rd_cand) begin
          arready_d = 1'b1;
          is_wr_d   = 1'b0;
          hit_d     = w_ar_hit;
          rd_prio_d = 1'b0;
          if (w_ar_hit) begin
            mst_addr_d  = araddr[APB_ADDRW-1:0];
            mst_wdata_d = '0;
            mst_strb_d  = '0;
          end
        end
      end

      ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // mst_ready is checked first so a reply on the final cycle still
        // completes as OKAY.
        if (mst_ready || (cnt_q == c_cnt_last)) begin
          mst_en_d = 1'b0;
          mst_wr_d = 1'b0;
          if (is_wr_q) begin
            state_d  = WRESP;
            bvalid_d = 1'b1;
            bresp_d  = mst_ready ? c_resp_okay : c_resp_slv;
          end else begin
            state_d  = RRESP;
            rvalid_d = 1'b1;
            rresp_d  = mst_ready ? c_resp_okay : c_resp_slv;
            rdata_d  = mst_ready ? mst_rdata : '0;
          end
        end
      end

      WRESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end

      RRESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Synchronous reset overrides everything computed above.
    if (srst) begin
      state_d     = IDLE;
      awready_d   = 1'b0;
      wready_d    = 1'b0;
      arready_d   = 1'b0;
      bvalid_d    = 1'b0;
      bresp_d     = 2'b00;
      rvalid_d    = 1'b0;
      rdata_d     = '0;
      rresp_d     = 2'b00;
      mst_en_d    = 1'b0;
      mst_wr_d    = 1'b0;
      mst_addr_d  = '0;
      mst_wdata_d = '0;
      mst_strb_d  = '0;
      rd_prio_d   = 1'b1;
      is_wr_d     = 1'b0;
      hit_d       = 1'b0;
      cnt_d       = 8'd0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= 2'b00;
      mst_en_q    <= 1'b0;
      mst_wr_q    <= 1'b0;
      mst_addr_q  <= '0;
      mst_wdata_q <= '0;
      mst_strb_q  <= '0;
      rd_prio_q   <= 1'b1;
      is_wr_q     <= 1'b0;
      hit_q       <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      arready_q   <= arready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      mst_en_q    <= mst_en_d;
      mst_wr_q    <= mst_wr_d;
      mst_addr_q  <= mst_addr_d;
      mst_wdata_q <= mst_wdata_d;
      mst_strb_q  <= mst_strb_d;
      rd_prio_q   <= rd_prio_d;
      is_wr_q     <= is_wr_d;
      hit_q       <= hit_d;
      cnt_q       <= cnt_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign arready   = arready_q;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign mst_en    = mst_en_q;
  assign mst_wr    = mst_wr_q;
  assign mst_addr  = mst_addr_q;
  assign mst_wdata = mst_wdata_q;
  assign mst_strb  = mst_strb_q;

endmodule
`default_nettype wire
